// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot stage for the single-cycle MIPS computer. Program words arrive on a
// valid/ready stream and are written into instruction memory starting at word
// address 0. The CPU is held in reset while the image loads and is released a
// fixed number of cycles after the final write.
//
// Optional feature macro: CHECKSUM_EN
//   defined   : the in_last word is a checksum (sum of data words mod 2**N),
//               not written to imem. A mismatch raises chk_err and parks in ERROR.
//   undefined : the in_last word is an ordinary data word; chk_err is tied 0.
//
// Parameters
//   N           data/instruction word width
//   AW          imem word-address width (2**AW words)
//   REL_CYCLES  cycles cpu_reset stays high after the final imem write (>= 1)
//
// Ports
//   clk         system clock, all state on posedge
//   reset       asynchronous active-low reset
//   start       one-cycle pulse, begin (re)load from address 0
//   in_valid    stream word valid
//   in_data     stream word
//   in_last     final word of the image
//   in_ready    loader accepts a word this cycle
//   imem_we     instruction-memory write enable (registered)
//   imem_addr   instruction-memory word address (registered)
//   imem_wdata  instruction-memory write data (registered)
//   cpu_reset   active-high reset to the computer (registered)
//   load_done   image loaded, CPU running
//   word_count  words written in the current load
//   ovf_err     image exceeded 2**AW words (sticky until start)
//   chk_err     checksum mismatch (sticky until start)
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int N          = 32,
  parameter int AW         = 6,
  parameter int REL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [N-1:0]  imem_wdata,
  output logic          cpu_reset,
  output logic          load_done,
  output logic [AW:0]   word_count,
  output logic          ovf_err,
  output logic          chk_err
);

  localparam int RCW = (REL_CYCLES > 1) ? $clog2(REL_CYCLES) : 1;
  localparam logic [RCW-1:0] REL_LAST = RCW'(REL_CYCLES - 1);
  // word_count value once every imem slot has been used
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t          state_reg,     state_next;
  logic [RCW-1:0]  rel_cnt_reg,   rel_cnt_next;
  logic            we_reg,        we_next;
  logic [AW-1:0]   addr_reg,      addr_next;
  logic [N-1:0]    wdata_reg,     wdata_next;
  logic            cpu_reset_reg, cpu_reset_next;
  logic            load_done_reg, load_done_next;
  logic [AW:0]     count_reg,     count_next;
  logic            ovf_reg,       ovf_next;
`ifdef CHECKSUM_EN
  logic            chk_reg,       chk_next;
  logic [N-1:0]    sum_reg,       sum_next;
`endif

  logic handshake;
  logic full;

  assign in_ready  = (state_reg == S_LOAD);
  assign handshake = in_valid && in_ready;
  assign full      = (count_reg == DEPTH);

  // ---------------------------------------------------------------------------
  // State register and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      rel_cnt_reg   <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cpu_reset_reg <= 1'b1;
      load_done_reg <= 1'b0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
`ifdef CHECKSUM_EN
      chk_reg       <= 1'b0;
      sum_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      rel_cnt_reg   <= rel_cnt_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      cpu_reset_reg <= cpu_reset_next;
      load_done_reg <= load_done_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
`ifdef CHECKSUM_EN
      chk_reg       <= chk_next;
      sum_reg       <= sum_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    rel_cnt_next   = rel_cnt_reg;
    we_next        = 1'b0;          // write strobe is a single-cycle pulse
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    cpu_reset_next = cpu_reset_reg;
    load_done_next = load_done_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
`ifdef CHECKSUM_EN
    chk_next       = chk_reg;
    sum_next       = sum_reg;
`endif

    if (start) begin
      // start has priority over everything, including a same-cycle handshake,
      // whose word is simply discarded.
      state_next     = S_LOAD;
      rel_cnt_next   = '0;
      cpu_reset_next = 1'b1;
      load_done_next = 1'b0;
      count_next     = '0;
      ovf_next       = 1'b0;
`ifdef CHECKSUM_EN
      chk_next       = 1'b0;
      sum_next       = '0;
`endif
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (handshake) begin
`ifdef CHECKSUM_EN
            if (in_last) begin
              // checksum word: compared, never written, never counted
              rel_cnt_next = '0;
              if (in_data == sum_reg) begin
                state_next = S_RELEASE;
              end else begin
                chk_next   = 1'b1;
                state_next = S_ERROR;
              end
            end else
`endif
            if (full) begin
              // image larger than imem: drop the word and park
              ovf_next   = 1'b1;
              state_next = S_ERROR;
            end else begin
              we_next    = 1'b1;
              addr_next  = count_reg[AW-1:0];
              wdata_next = in_data;
              count_next = count_reg + 1'b1;
`ifdef CHECKSUM_EN
              sum_next   = sum_reg + in_data;
`endif
              if (in_last) begin
                rel_cnt_next = '0;
                state_next   = S_RELEASE;
              end
            end
          end
        end

        S_RELEASE: begin
          // The first RELEASE cycle coincides with the final imem_we, so
          // REL_CYCLES cycles here put the cpu_reset fall REL_CYCLES cycles
          // after that write.
          if (rel_cnt_reg == REL_LAST) begin
            state_next     = S_RUN;
            cpu_reset_next = 1'b0;
            load_done_next = 1'b1;
          end else begin
            rel_cnt_next = rel_cnt_reg + 1'b1;
          end
        end

        default: begin
          // IDLE, RUN and ERROR only leave on start
        end
      endcase
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign load_done  = load_done_reg;
  assign word_count = count_reg;
  assign ovf_err    = ovf_reg;
`ifdef CHECKSUM_EN
  assign chk_err    = chk_reg;
`else
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed bench for imem_boot_loader (AW=2 so overflow is reachable).
// A reference model describes the loader in terms of "loading", a word tally,
// a running sum and a release countdown; a compare process checks every DUT
// output against it on each falling clock edge. Hand-computed literal checks
// pin the model at key points of each scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int N     = 32;
  localparam int AW    = 2;
  localparam int REL   = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data  = '0;
  logic          in_last  = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [N-1:0]  imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          ovf_err;
  logic          chk_err;

  imem_boot_loader #(.N(N), .AW(AW), .REL_CYCLES(REL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .word_count (word_count),
    .ovf_err    (ovf_err),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_we_cyc = -1;
  logic [N-1:0] tb_mem [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit            m_loading   = 1'b0;
  int            m_count     = 0;
  int            m_rel_left  = 0;
  logic [N-1:0]  m_sum       = '0;
  bit            e_we        = 1'b0;
  bit            e_cpu_reset = 1'b1;
  bit            e_load_done = 1'b0;
  bit            e_ovf       = 1'b0;
  bit            e_chk       = 1'b0;
  logic [AW-1:0] e_addr      = '0;
  logic [N-1:0]  e_wdata     = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_loading   <= 1'b0;
      m_count     <= 0;
      m_rel_left  <= 0;
      m_sum       <= '0;
      e_we        <= 1'b0;
      e_cpu_reset <= 1'b1;
      e_load_done <= 1'b0;
      e_ovf       <= 1'b0;
      e_chk       <= 1'b0;
      e_addr      <= '0;
      e_wdata     <= '0;
    end else begin
      e_we <= 1'b0;
      if (start) begin
        m_loading   <= 1'b1;
        m_count     <= 0;
        m_rel_left  <= 0;
        m_sum       <= '0;
        e_cpu_reset <= 1'b1;
        e_load_done <= 1'b0;
        e_ovf       <= 1'b0;
        e_chk       <= 1'b0;
      end else if (m_loading && in_valid) begin
`ifdef CHECKSUM_EN
        if (in_last) begin
          m_loading <= 1'b0;
          if (in_data == m_sum) m_rel_left <= REL;
          else                  e_chk      <= 1'b1;
        end else
`endif
        if (m_count == DEPTH) begin
          m_loading <= 1'b0;
          e_ovf     <= 1'b1;
        end else begin
          e_we    <= 1'b1;
          e_addr  <= AW'(m_count);
          e_wdata <= in_data;
          m_count <= m_count + 1;
          m_sum   <= m_sum + in_data;
          if (in_last) begin
            m_loading  <= 1'b0;
            m_rel_left <= REL;
          end
        end
      end else if (m_rel_left > 0) begin
        m_rel_left <= m_rel_left - 1;
        if (m_rel_left == 1) begin
          e_cpu_reset <= 1'b0;
          e_load_done <= 1'b1;
        end
      end
    end
  end

  // Compare process: every output, every cycle
  always @(negedge clk) begin
    check("in_ready",   in_ready,   m_loading);
    check("imem_we",    imem_we,    e_we);
    check("imem_addr",  imem_addr,  e_addr);
    check("imem_wdata", imem_wdata, e_wdata);
    check("cpu_reset",  cpu_reset,  e_cpu_reset);
    check("load_done",  load_done,  e_load_done);
    check("word_count", word_count, m_count);
    check("ovf_err",    ovf_err,    e_ovf);
    check("chk_err",    chk_err,    e_chk);
  end

  // Capture imem writes, one line per write transaction
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      tb_mem[imem_addr] <= imem_wdata;
      last_we_cyc       <= cyc;
      $display("write addr=%0d data=0x%08h (t=%0t)", imem_addr, imem_wdata, $time);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit s, input bit v, input logic [N-1:0] d, input bit l);
    @(negedge clk);
    start    = s;
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_release(input string name, output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_reset === 1'b0) begin
        fall_cyc = cyc;
        break;
      end
    end
    if (fall_cyc < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: cpu_reset still 0x%0h after 20 cycles, expected 0x0", name, cpu_reset);
    end
  endtask

  int fall;

  initial begin
    // Reset state
    idle(2);
    check("reset cpu_reset",  cpu_reset,  1'b1);
    check("reset in_ready",   in_ready,   1'b0);
    check("reset word_count", word_count, 0);
    check("reset imem_we",    imem_we,    1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    idle(1);

`ifdef CHECKSUM_EN
    // T5: 1 + 2 = 3 matches
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h1, 0);
    drive(0, 1, 32'h2, 0);
    drive(0, 1, 32'h3, 1);
    drive(0, 0, '0, 0);
    wait_release("T5 good release", fall);
    check("T5 load_done",  load_done,  1'b1);
    check("T5 word_count", word_count, 2);
    check("T5 mem1",       tb_mem[1],  32'h2);
    idle(2);
    // T5: checksum 4 mismatches
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h1, 0);
    drive(0, 1, 32'h2, 0);
    drive(0, 1, 32'h4, 1);
    idle(3);
    check("T5 chk_err",   chk_err,   1'b1);
    check("T5 cpu_reset", cpu_reset, 1'b1);
    // Checksum-only image expects 0
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h0, 1);
    drive(0, 0, '0, 0);
    wait_release("T5 empty release", fall);
    check("T5 empty load_done", load_done, 1'b1);
    check("T5 empty chk_err",   chk_err,   1'b0);
    idle(2);
`else
    // T1: three-word image
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h20080005, 0);
    drive(0, 1, 32'h20090003, 0);
    drive(0, 1, 32'h01095020, 1);
    drive(0, 0, '0, 0);
    check("T1 in_ready dropped", in_ready, 1'b0);
    wait_release("T1 release", fall);
    check("T1 release delay", fall - last_we_cyc, REL);
    check("T1 mem0", tb_mem[0], 32'h20080005);
    check("T1 mem1", tb_mem[1], 32'h20090003);
    check("T1 mem2", tb_mem[2], 32'h01095020);
    check("T1 word_count", word_count, 3);
    check("T1 load_done",  load_done,  1'b1);
    idle(2);

    // T2: in_valid 1,0,1,0 then a last word
    drive(1, 0, '0, 0);
    drive(0, 1, 32'hAAAA0001, 0);
    drive(0, 0, '0, 0);
    check("T2 we after valid0", imem_we,   1'b1);
    check("T2 addr0",           imem_addr, 0);
    drive(0, 1, 32'hAAAA0002, 0);
    check("T2 we after gap0",   imem_we,   1'b0);
    drive(0, 0, '0, 0);
    check("T2 we after valid1", imem_we,   1'b1);
    check("T2 addr1",           imem_addr, 1);
    drive(0, 1, 32'hAAAA0003, 1);
    check("T2 we after gap1",   imem_we,   1'b0);
    drive(0, 0, '0, 0);
    wait_release("T2 release", fall);
    check("T2 mem1", tb_mem[1], 32'hAAAA0002);
    check("T2 word_count", word_count, 3);
    idle(1);

    // T6: start in RUN
    drive(1, 0, '0, 0);
    drive(0, 0, '0, 0);
    check("T6 cpu_reset", cpu_reset,  1'b1);
    check("T6 load_done", load_done,  1'b0);
    check("T6 count",     word_count, 0);
    // start with a same-cycle handshake discards the word
    drive(0, 1, 32'hD0D0D0D0, 0);
    drive(1, 1, 32'hEEEEEEEE, 0);
    drive(0, 1, 32'hF0F0F0F0, 1);
    drive(0, 0, '0, 0);
    wait_release("T6 release", fall);
    check("T6 mem0",       tb_mem[0],  32'hF0F0F0F0);
    check("T6 word_count", word_count, 1);
    // start while in RELEASE restarts from address 0
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h11111111, 1);
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h22222222, 1);
    drive(0, 0, '0, 0);
    wait_release("T6 rel-restart release", fall);
    check("T6 restart mem0",  tb_mem[0],  32'h22222222);
    check("T6 restart count", word_count, 1);
    idle(1);

    // T3: five words into a four-word imem
    drive(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 32'hC0DE0000 + i, 0);
    idle(3);
    check("T3 ovf_err",    ovf_err,    1'b1);
    check("T3 cpu_reset",  cpu_reset,  1'b1);
    check("T3 word_count", word_count, 4);
    check("T3 mem3",       tb_mem[3],  32'hC0DE0003);
    check("T3 in_ready",   in_ready,   1'b0);
    drive(0, 1, 32'h99999999, 1);
    idle(2);
    check("T3 ovf sticky", ovf_err,    1'b1);

    // T4: reset mid-load, then a one-word reload
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h44440000, 0);
    drive(0, 1, 32'h44440001, 0);
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("T4 in_ready",   in_ready,   1'b0);
    check("T4 imem_we",    imem_we,    1'b0);
    check("T4 imem_addr",  imem_addr,  0);
    check("T4 imem_wdata", imem_wdata, 0);
    check("T4 cpu_reset",  cpu_reset,  1'b1);
    check("T4 load_done",  load_done,  1'b0);
    check("T4 word_count", word_count, 0);
    check("T4 ovf_err",    ovf_err,    1'b0);
    check("T4 chk_err",    chk_err,    1'b0);
    idle(1);
    @(negedge clk);
    #2 reset = 1'b1;
    drive(1, 0, '0, 0);
    drive(0, 1, 32'h55555555, 1);
    drive(0, 0, '0, 0);
    wait_release("T4 release", fall);
    check("T4 mem0",      tb_mem[0], 32'h55555555);
    check("T4 load_done", load_done, 1'b1);
    idle(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
